// File: rtl/lsu_mem_if.sv
// RV32I load/store unit front end: formats CPU requests onto a single-cycle-read
// word RAM port. Define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses.
module lsu_mem_if #(
  parameter int WORD_ADDR_W = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        accept, illegal_f3, misalign, fault_req, issue;
  logic [1:0]  off, eff_off;
  logic [3:0]  be_base;
  logic [31:0] wd_sz, ld_sh, rdata_ld_d;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[1:0];

  assign illegal_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_we && req_funct3[2]);

  // Aligned accesses see eff_off == off, so one lane offset serves both builds.
  always_comb begin
    eff_off = off;
    if (req_funct3[1:0] == 2'b01) eff_off = {off[1], 1'b0};
    else if (req_funct3[1])       eff_off = 2'b00;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign fault_req = illegal_f3 || misalign;
  assign issue     = accept && !fault_req;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   begin be_base = 4'b0001; wd_sz = {24'b0, req_wdata[7:0]};  end
      2'b01:   begin be_base = 4'b0011; wd_sz = {16'b0, req_wdata[15:0]}; end
      default: begin be_base = 4'b1111; wd_sz = req_wdata;                end
    endcase
  end

  assign mem_address = issue ? {{(32-WORD_ADDR_W){1'b0}}, req_addr[WORD_ADDR_W+1:2]} : 32'b0;
  assign mem_byteena = issue ? (be_base << eff_off) : 4'b0;
  assign mem_data    = (issue && req_we) ? (wd_sz << {eff_off, 3'b000}) : 32'b0;
  assign mem_wren    = issue && req_we;

  // RAM returns the selected lanes in place; bring them down to bit 0 and extend.
  assign ld_sh = mem_q >> {off_q, 3'b000};
  always_comb begin
    case (f3_q)
      3'b000:  rdata_ld_d = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b100:  rdata_ld_d = {24'b0, ld_sh[7:0]};
      3'b001:  rdata_ld_d = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b101:  rdata_ld_d = {16'b0, ld_sh[15:0]};
      default: rdata_ld_d = ld_sh;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      off_q   <= 2'b0;
      f3_q    <= 3'b0;
      rdata_q <= 32'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rdata_q <= 32'b0;
          fault_q <= fault_req;
          if (fault_req || req_we) begin
            state_q <= RESP;
          end else begin
            state_q <= LOAD_WAIT;
            off_q   <= eff_off;
            f3_q    <= req_funct3;
          end
        end
        LOAD_WAIT: begin
          rdata_q <= rdata_ld_d;
          fault_q <= 1'b0;
          state_q <= RESP;
        end
        RESP: if (resp_ready) begin
          rdata_q <= 32'b0;
          fault_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state_q == RESP) && !reset;
  assign resp_rdata = reset ? 32'b0 : rdata_q;
  assign resp_fault = fault_q && !reset;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: byte-level memory model predicts every
// transaction, a negedge process compares all outputs each cycle.
module tb_lsu_mem_if;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata, mem_address, mem_data, mem_q;
  logic [3:0]  mem_byteena;
  logic        mem_wren;

  int vectors = 0;
  int miscompares = 0;

  lsu_mem_if #(.WORD_ADDR_W(30)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // RAM environment: lane writes, registered read with unselected lanes zeroed.
  logic [31:0] ram [16];
  always @(posedge clock) begin
    logic [31:0] msk;
    msk = {{8{mem_byteena[3]}}, {8{mem_byteena[2]}}, {8{mem_byteena[1]}}, {8{mem_byteena[0]}}};
    if (mem_wren) ram[mem_address[3:0]] <= (ram[mem_address[3:0]] & ~msk) | (mem_data & msk);
    mem_q <= (!mem_wren && (mem_byteena != 4'b0)) ? (ram[mem_address[3:0]] & msk) : 32'b0;
  end

  // Reference model: plain byte array.
  logic [7:0] mdl [64];

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_wren, exp_rv, exp_fault, exp_rst, chk_md;
  logic [31:0] exp_addr, exp_md, exp_rdata;
  logic [3:0]  exp_be;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) if (chk_en) begin
    cmp("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    cmp("mem_address", mem_address, exp_addr);
    cmp("mem_byteena", {28'b0, mem_byteena}, {28'b0, exp_be});
    cmp("mem_wren", {31'b0, mem_wren}, {31'b0, exp_wren});
    if (chk_md) cmp("mem_data", mem_data, exp_md);
    cmp("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
    if (exp_rv || exp_rst) begin
      cmp("resp_rdata", resp_rdata, exp_rdata);
      cmp("resp_fault", {31'b0, resp_fault}, {31'b0, exp_fault});
    end
  end

  task automatic set_idle(input logic rdy);
    exp_ready = rdy; exp_addr = 0; exp_be = 0; exp_wren = 0; exp_md = 0;
    chk_md = 1; exp_rv = 0; exp_rdata = 0; exp_fault = 0;
  endtask

  task automatic garbage();
    req_valid  = 1'b1;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic idle_cycle();
    @(posedge clock); #1;
    req_valid = 0; exp_rst = 0;
    set_idle(1'b1);
  endtask

  // One transaction from IDLE through handshake; lit_* are hand-computed values.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, input logic [31:0] lit_be,
                      input logic [31:0] lit_rd, input logic [31:0] lit_flt);
    logic [1:0] o, eo; int sz; logic flt; logic [3:0] be; logic [31:0] md, rd; logic [5:0] wb;
    o  = addr[1:0];
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2 && o[0]) flt = 1;
    if (sz == 4 && o != 2'd0) flt = 1;
`endif
    eo = (sz == 4) ? 2'd0 : (sz == 2) ? (o & 2'b10) : o;
    be = 0; md = 0; rd = 0; wb = {addr[5:2], 2'b00};
    if (!flt)
      for (int i = 0; i < sz; i++) begin
        be[int'(eo) + i] = 1'b1;
        if (we) md[8*(int'(eo)+i) +: 8] = wd[8*i +: 8];
        else    rd[8*i +: 8] = mdl[wb + 6'(eo) + 6'(i)];
      end
    if (!flt && !we && !f3[2] && rd[8*sz-1])
      for (int i = sz; i < 4; i++) rd[8*i +: 8] = 8'hFF;

    @(posedge clock); #1;
    exp_rst = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = 0;
    set_idle(1'b1);
    exp_addr = flt ? 32'b0 : {2'b0, addr[31:2]};
    exp_be = be; exp_wren = !flt && we; exp_md = md; chk_md = we || flt;
    #1 cmp("lit_byteena", {28'b0, mem_byteena}, lit_be);
    if (!flt && we)
      for (int i = 0; i < 4; i++) if (be[i]) mdl[wb + 6'(i)] = md[8*i +: 8];

    @(posedge clock); #1;
    garbage();
    set_idle(1'b0);
    exp_rv = flt || we; exp_rdata = rd; exp_fault = flt;
    if (!flt && !we) begin
      @(posedge clock); #1;
      garbage();
      exp_rv = 1;
    end
    resp_ready = (stall == 0);
    #1;
    cmp("lit_rdata", resp_rdata, lit_rd);
    cmp("lit_fault", {31'b0, resp_fault}, lit_flt);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      garbage();
      resp_ready = (i == stall - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 0;
    for (int i = 0; i < 64; i++) mdl[i] = 0;
    reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0;
    @(posedge clock); #1;
    set_idle(1'b0); exp_rst = 1; chk_en = 1;
    @(posedge clock); #1;
    reset = 0; exp_rst = 1; set_idle(1'b1);

    xact(1, 3'b010, 32'h8, 32'hDEADBEEF, 0, 32'hF, 32'h0, 0);
    cmp("sw_addr_seen", {28'b0, ram[2][31:28]}, 32'hD);
    xact(0, 3'b000, 32'hB, 32'h0, 0, 32'h8, 32'hFFFFFFDE, 0);
    xact(0, 3'b100, 32'hB, 32'h0, 0, 32'h8, 32'h000000DE, 0);
    xact(1, 3'b001, 32'h6, 32'h1234, 0, 32'hC, 32'h0, 0);
    xact(0, 3'b101, 32'h6, 32'h0, 0, 32'hC, 32'h00001234, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    xact(0, 3'b010, 32'h5, 32'h0, 0, 32'h0, 32'h0, 1);
    xact(0, 3'b001, 32'h7, 32'h0, 0, 32'h0, 32'h0, 1);
`else
    xact(0, 3'b010, 32'h5, 32'h0, 0, 32'hF, 32'h12340000, 0);
    xact(0, 3'b001, 32'h7, 32'h0, 0, 32'hC, 32'h00001234, 0);
`endif
    xact(0, 3'b011, 32'h0, 32'h0, 3, 32'h0, 32'h0, 1);
    xact(1, 3'b100, 32'h8, 32'h77, 0, 32'h0, 32'h0, 1);
    xact(0, 3'b110, 32'h4, 32'h0, 0, 32'h0, 32'h0, 1);
    xact(1, 3'b111, 32'h4, 32'h0, 1, 32'h0, 32'h0, 1);
    xact(1, 3'b000, 32'h1, 32'hAB80, 0, 32'h2, 32'h0, 0);
    xact(0, 3'b000, 32'h1, 32'h0, 2, 32'h2, 32'hFFFFFF80, 0);
    xact(0, 3'b001, 32'h0, 32'h0, 0, 32'h3, 32'hFFFF8000, 0);
    xact(1, 3'b000, 32'h9, 32'h55, 1, 32'h2, 32'h0, 0);
    xact(0, 3'b010, 32'h8, 32'h0, 0, 32'hF, 32'hDEAD55EF, 0);

    // Reset lands while the load waits on mem_q.
    @(posedge clock); #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 0;
    resp_ready = 1;
    set_idle(1'b1); exp_addr = 32'h2; exp_be = 4'hF; chk_md = 0;
    @(posedge clock); #1;
    req_valid = 0; reset = 1; exp_rst = 1; set_idle(1'b0);
    @(posedge clock); #1;
    reset = 0; exp_rst = 1; set_idle(1'b1);
    #1 cmp("rst_ready", {31'b0, req_ready}, 32'h1);
    xact(0, 3'b100, 32'hA, 32'h0, 0, 32'h4, 32'h000000AD, 0);
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
